// File: rtl/stat_display_if.sv
// Counter bundle from the statistic unit to the display: source select, the five
// 32-bit counters and the halt flag.
interface stat_display_if;
   logic [2:0]  sel;
   logic [31:0] total_cycles;
   logic [31:0] uncondi_num;
   logic [31:0] condi_num;
   logic [31:0] condi_suc_num;
   logic [31:0] SyscallOut;
   logic        halt;

   modport master (
      output sel, total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut, halt
   );

   modport slave (
      input sel, total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut, halt
   );
endinterface

// File: rtl/stat_display.sv
// Scans one selected statistic counter as 8 hex digits onto a common-anode
// 7-segment display, refreshing the shown value only at frame wrap.
module stat_display #(
   parameter int SCAN_DIV = 100000,
   parameter bit BLANK_LZ = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   stat_display_if.slave     stat,
   output logic [7:0]        an,
   output logic [6:0]        seg,
   output logic              dp
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [2:0]    digit;
   logic [31:0]   snap;

   logic          tick;
   logic [2:0]    digit_new;
   logic [31:0]   src;
   logic [31:0]   snap_new;
   logic [31:0]   shifted;
   logic [3:0]    nibble;
   logic          blank;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      src = 32'h0;
      case (stat.sel)
         3'd0: src = stat.total_cycles;
         3'd1: src = stat.uncondi_num;
         3'd2: src = stat.condi_num;
         3'd3: src = stat.condi_suc_num;
         3'd4: src = stat.SyscallOut;
         3'd5: src = stat.condi_num - stat.condi_suc_num;
         default: src = 32'h0;
      endcase
   end

   // The snapshot taken at the 7->0 wrap must already feed digit 0 of the same update.
   always_comb begin
      tick      = (div_cnt == DIV_MAX);
      digit_new = digit + 3'd1;
      snap_new  = (tick && (digit == 3'd7)) ? src : snap;
      shifted   = snap_new >> {digit_new, 2'b00};
      nibble    = shifted[3:0];
      blank     = BLANK_LZ && (digit_new != 3'd0) && (shifted == 32'h0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         digit   <= 3'd0;
         snap    <= 32'h0;
         an      <= 8'hFF;
         seg     <= 7'h7F;
         dp      <= 1'b1;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DW'(1);
         if (tick) begin
            digit <= digit_new;
            snap  <= snap_new;
            an    <= ~(8'b1 << digit_new);
            seg   <= blank ? 7'h7F : hex7(nibble);
            dp    <= ~((digit_new == 3'd0) && stat.halt);
         end
      end
   end

endmodule
